// File: rtl/number_baseball_core.sv
// number_baseball_core: parametrised number-baseball game engine.
// Level buttons are edge-detected internally. seg_data is registered and
// carries one 5-bit display code per field.
// Optional feature macro RANDOM_ANSWER_EN: the answer comes from a free-running
// LFSR instead of manual entry.
module number_baseball_core #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_MAX    = 9,
    parameter int MAX_ATTEMPTS = 16,
    parameter int BLINK_DIV    = 50_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    active,
    input  logic                    btn_up,
    input  logic                    btn_down,
    input  logic                    btn_left,
    input  logic                    btn_right,
    input  logic                    btn_confirm,
    output logic [MAX_ATTEMPTS-1:0] led,
    output logic [5*NUM_DIGITS-1:0] seg_data,
    output logic [3:0]              strike_count,
    output logic [3:0]              ball_count,
    output logic                    game_won,
    output logic                    game_over
);
    localparam int CW = $clog2(NUM_DIGITS);
    localparam int AW = $clog2(MAX_ATTEMPTS + 1);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [4:0] C_HY = 5'd10, C_E = 5'd11, C_R = 5'd12, C_L = 5'd13;
    localparam logic [4:0] C_O = 5'd17, C_B = 5'd18, C_D = 5'd19, C_G = 5'd9;
    localparam logic [4:0] C_S = 5'd5, C_BL = 5'd31;

    typedef logic [NUM_DIGITS-1:0][3:0] digits_t;
    typedef logic [NUM_DIGITS-1:0][4:0] disp_t;

    typedef enum logic [3:0] {
        IDLE, INPUT_ANSWER, ANSWER_CONFIRM, INPUT_GUESS,
        GUESS_ERR, SHOW_RESULT, GAME_WIN, GAME_LOSE
`ifdef RANDOM_ANSWER_EN
        , GEN_ANSWER
`endif
    } state_t;

`ifdef RANDOM_ANSWER_EN
    localparam state_t START_ST = GEN_ANSWER;
`else
    localparam state_t START_ST = INPUT_ANSWER;
`endif

    state_t            state_q, state_d;
    digits_t           answer_q, answer_d, guess_q, guess_d;
    logic [CW-1:0]     cursor_q, cursor_d;
    logic [AW-1:0]     attempts_q, attempts_d;
    logic [MAX_ATTEMPTS-1:0] led_q, led_d;
    logic [3:0]        strike_q, strike_d, ball_q, ball_d, strike_c, ball_c;
    logic [4:0]        btn_prev_q, btn_now, btn_ev;
    logic [5*NUM_DIGITS-1:0] seg_q;
    disp_t             disp;
    logic [BW-1:0]     blink_cnt_q;
    logic              blink_q;
    logic              ans_dup, guess_dup;
`ifdef RANDOM_ANSWER_EN
    logic [15:0]       lfsr_q;
    logic [CW-1:0]     gen_pos_q, gen_pos_d;
    logic              gen_used;
`endif

    assign btn_now = {btn_confirm, btn_right, btn_left, btn_down, btn_up};
    assign btn_ev  = btn_now & ~btn_prev_q;

    function automatic logic has_dup(input digits_t d);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++)
            for (int j = i + 1; j < NUM_DIGITS; j++)
                if (d[i] == d[j]) r = 1'b1;
        return r;
    endfunction

    // up beats down; only the digit under the cursor changes
    function automatic digits_t edit(input digits_t d, input logic [CW-1:0] cur,
                                     input logic up, input logic dn);
        digits_t r;
        r = d;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (cur == CW'(i)) begin
                if (up)      r[i] = (d[i] == 4'(DIGIT_MAX)) ? 4'd0 : d[i] + 4'd1;
                else if (dn) r[i] = (d[i] == 4'd0) ? 4'(DIGIT_MAX) : d[i] - 4'd1;
            end
        return r;
    endfunction

    // left (toward MSB) beats right; both wrap
    function automatic logic [CW-1:0] move(input logic [CW-1:0] cur, input logic lf, input logic rt);
        logic [CW-1:0] r;
        r = cur;
        if (lf)      r = (cur == CW'(NUM_DIGITS - 1)) ? '0 : cur + CW'(1);
        else if (rt) r = (cur == '0) ? CW'(NUM_DIGITS - 1) : cur - CW'(1);
        return r;
    endfunction

    // Four-character message in the leftmost fields, lower fields blank
    function automatic disp_t msg(input logic [4:0] a, input logic [4:0] b,
                                  input logic [4:0] c, input logic [4:0] d);
        disp_t m;
        m = {NUM_DIGITS{C_BL}};
        m[NUM_DIGITS-1] = a;
        m[NUM_DIGITS-2] = b;
        m[NUM_DIGITS-3] = c;
        m[NUM_DIGITS-4] = d;
        return m;
    endfunction

    assign ans_dup   = has_dup(answer_q);
    assign guess_dup = has_dup(guess_q);

    // Strikes and balls of the registered guess against the registered answer
    always_comb begin
        strike_c = '0;
        ball_c   = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            for (int j = 0; j < NUM_DIGITS; j++)
                if (guess_q[i] == answer_q[j]) begin
                    if (i == j) strike_c = strike_c + 4'd1;
                    else        ball_c   = ball_c + 4'd1;
                end
    end

`ifdef RANDOM_ANSWER_EN
    // Candidate LFSR digit already present in a filled answer position
    always_comb begin
        gen_used = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (CW'(i) < gen_pos_q && answer_q[i] == lfsr_q[3:0]) gen_used = 1'b1;
    end
`endif

    // Next-state and datapath updates; confirm pre-empts any edit in the same cycle
    always_comb begin
        state_d    = state_q;
        answer_d   = answer_q;
        guess_d    = guess_q;
        cursor_d   = cursor_q;
        attempts_d = attempts_q;
        led_d      = led_q;
        strike_d   = strike_q;
        ball_d     = ball_q;
`ifdef RANDOM_ANSWER_EN
        gen_pos_d  = gen_pos_q;
`endif
        case (state_q)
            IDLE: begin
                state_d  = START_ST;
                cursor_d = '0;
`ifdef RANDOM_ANSWER_EN
                gen_pos_d = '0;
`endif
            end
            INPUT_ANSWER: begin
                if (btn_ev[4]) state_d = ANSWER_CONFIRM;
                else begin
                    answer_d = edit(answer_q, cursor_q, btn_ev[0], btn_ev[1]);
                    cursor_d = move(cursor_q, btn_ev[2], btn_ev[3]);
                end
            end
            ANSWER_CONFIRM: begin
                if (btn_ev[4]) begin
                    state_d  = ans_dup ? INPUT_ANSWER : INPUT_GUESS;
                    cursor_d = '0;
                end
            end
            INPUT_GUESS: begin
                if (btn_ev[4]) begin
                    if (guess_dup) state_d = GUESS_ERR;
                    else begin
                        strike_d   = strike_c;
                        ball_d     = ball_c;
                        attempts_d = attempts_q + AW'(1);
                        for (int k = 0; k < MAX_ATTEMPTS; k++)
                            if (attempts_q == AW'(k)) led_d[k] = 1'b1;
                        if (strike_c == 4'(NUM_DIGITS))                 state_d = GAME_WIN;
                        else if (attempts_d == AW'(MAX_ATTEMPTS))       state_d = GAME_LOSE;
                        else                                            state_d = SHOW_RESULT;
                    end
                end else begin
                    guess_d  = edit(guess_q, cursor_q, btn_ev[0], btn_ev[1]);
                    cursor_d = move(cursor_q, btn_ev[2], btn_ev[3]);
                end
            end
            GUESS_ERR, SHOW_RESULT: begin
                if (btn_ev[4]) begin
                    state_d  = INPUT_GUESS;
                    cursor_d = '0;
                end
            end
            GAME_WIN, GAME_LOSE: begin
                if (btn_ev[4]) begin
                    state_d    = START_ST;
                    cursor_d   = '0;
                    attempts_d = '0;
                    led_d      = '0;
                    strike_d   = '0;
                    ball_d     = '0;
                    answer_d   = '0;
                    guess_d    = '0;
`ifdef RANDOM_ANSWER_EN
                    gen_pos_d  = '0;
`endif
                end
            end
`ifdef RANDOM_ANSWER_EN
            GEN_ANSWER: begin
                if (lfsr_q[3:0] <= 4'(DIGIT_MAX) && !gen_used) begin
                    for (int i = 0; i < NUM_DIGITS; i++)
                        if (gen_pos_q == CW'(i)) answer_d[i] = lfsr_q[3:0];
                    if (gen_pos_q == CW'(NUM_DIGITS - 1)) begin
                        state_d   = INPUT_GUESS;
                        cursor_d  = '0;
                        gen_pos_d = '0;
                    end else gen_pos_d = gen_pos_q + CW'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Display codes derived from the current state; registered below
    always_comb begin
        disp = '0;
        case (state_q)
            INPUT_ANSWER, INPUT_GUESS: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    disp[i] = {1'b0, (state_q == INPUT_ANSWER) ? answer_q[i] : guess_q[i]};
                    if (blink_q && cursor_q == CW'(i)) disp[i] = C_BL;
                end
            end
            ANSWER_CONFIRM: disp = ans_dup ? msg(C_HY, C_E, C_R, C_R) : msg(C_G, C_O, C_G, C_O);
            GUESS_ERR:      disp = msg(C_HY, C_E, C_R, C_R);
            SHOW_RESULT:    disp = msg({1'b0, strike_q}, C_S, {1'b0, ball_q}, C_B);
            GAME_WIN:       disp = msg(C_G, C_O, C_O, C_D);
            GAME_LOSE:      disp = msg(C_L, C_O, C_S, C_E);
`ifdef RANDOM_ANSWER_EN
            GEN_ANSWER:     disp = {NUM_DIGITS{C_HY}};
`endif
            default:        disp = '0;
        endcase
    end

    // State and datapath registers; active low clears them synchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset || !active) begin
            state_q    <= IDLE;
            answer_q   <= '0;
            guess_q    <= '0;
            cursor_q   <= '0;
            attempts_q <= '0;
            led_q      <= '0;
            strike_q   <= '0;
            ball_q     <= '0;
            btn_prev_q <= '0;
            seg_q      <= '0;
`ifdef RANDOM_ANSWER_EN
            gen_pos_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            answer_q   <= answer_d;
            guess_q    <= guess_d;
            cursor_q   <= cursor_d;
            attempts_q <= attempts_d;
            led_q      <= led_d;
            strike_q   <= strike_d;
            ball_q     <= ball_d;
            btn_prev_q <= btn_now;
            seg_q      <= disp;
`ifdef RANDOM_ANSWER_EN
            gen_pos_q  <= gen_pos_d;
`endif
        end
    end

    // Blink phase toggles every BLINK_DIV cycles; the counter ignores active
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            if (blink_cnt_q == BW'(BLINK_DIV - 1)) blink_cnt_q <= '0;
            else                                   blink_cnt_q <= blink_cnt_q + BW'(1);
            if (!active)                                blink_q <= 1'b0;
            else if (blink_cnt_q == BW'(BLINK_DIV - 1)) blink_q <= ~blink_q;
        end
    end

`ifdef RANDOM_ANSWER_EN
    // Free-running Fibonacci LFSR, taps 16,14,13,11
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
`endif

    assign led          = led_q;
    assign seg_data     = seg_q;
    assign strike_count = strike_q;
    assign ball_count   = ball_q;
    assign game_won     = (state_q == GAME_WIN);
    assign game_over    = (state_q == GAME_WIN) || (state_q == GAME_LOSE);
endmodule

// File: tb/tb_number_baseball_core.sv
// Self-checking bench for number_baseball_core: a default 4-digit instance (a)
// and a 5-digit, 3-attempt instance (b). Table rows drive button presses and
// queue expected outputs which are popped and compared once the press settles.
module tb_number_baseball_core;
    logic clk = 1'b0;
    logic rst_a, rst_b, act_a, act_b;
    logic [4:0] btn_a, btn_b;   // {confirm, right, left, down, up}

    logic [15:0] led_a;  logic [19:0] seg_a;  logic [3:0] s_a, b_a;  logic won_a, over_a;
    logic [2:0]  led_b;  logic [24:0] seg_b;  logic [3:0] s_b, b_b;  logic won_b, over_b;

    number_baseball_core dut_a (
        .clk(clk), .reset(rst_a), .active(act_a),
        .btn_up(btn_a[0]), .btn_down(btn_a[1]), .btn_left(btn_a[2]), .btn_right(btn_a[3]),
        .btn_confirm(btn_a[4]), .led(led_a), .seg_data(seg_a),
        .strike_count(s_a), .ball_count(b_a), .game_won(won_a), .game_over(over_a));

    number_baseball_core #(.NUM_DIGITS(5), .MAX_ATTEMPTS(3)) dut_b (
        .clk(clk), .reset(rst_b), .active(act_b),
        .btn_up(btn_b[0]), .btn_down(btn_b[1]), .btn_left(btn_b[2]), .btn_right(btn_b[3]),
        .btn_confirm(btn_b[4]), .led(led_b), .seg_data(seg_b),
        .strike_count(s_b), .ball_count(b_b), .game_won(won_b), .game_over(over_b));

    always #5 clk = ~clk;

    localparam logic [4:0] U = 5'd1, D = 5'd2, L = 5'd4, R = 5'd8, C = 5'd16;

    typedef struct {
        int          sel;
        logic [4:0]  mask;
        int          rep;
        bit          chk;
        logic [39:0] seg;
        logic [31:0] led;
        logic [3:0]  s, b;
        logic        won, over;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [39:0] s4(input int a, input int b, input int c, input int d);
        return {20'd0, 5'(a), 5'(b), 5'(c), 5'(d)};
    endfunction

    function automatic logic [39:0] s5(input int a, input int b, input int c, input int d, input int e);
        return {15'd0, 5'(a), 5'(b), 5'(c), 5'(d), 5'(e)};
    endfunction

    task automatic add(input int sel, input logic [4:0] mask, input int rep, input bit chk,
                       input logic [39:0] seg, input int led, input int s, input int b,
                       input logic won, input logic over);
        vec_t v;
        v.sel = sel; v.mask = mask; v.rep = rep; v.chk = chk; v.seg = seg;
        v.led = 32'(led); v.s = 4'(s); v.b = 4'(b); v.won = won; v.over = over;
        tbl.push_back(v);
    endtask

    task automatic st(input int sel, input logic [4:0] mask, input int rep);
        add(sel, mask, rep, 1'b0, 40'd0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One press: level high for one cycle, then low, then settle a cycle so
    // the registered seg_data reflects the new state.
    task automatic press(input int sel, input logic [4:0] m);
        @(negedge clk);
        if (sel == 0) btn_a = m; else btn_b = m;
        @(negedge clk);
        btn_a = '0;
        btn_b = '0;
        @(negedge clk);
    endtask

    task automatic compare(input string tag);
        vec_t e;
        logic [39:0] seg; logic [31:0] led; logic [3:0] s, b; logic won, over;
        e = sb.pop_front();
        if (e.sel == 0) begin
            seg = {20'd0, seg_a}; led = {16'd0, led_a}; s = s_a; b = b_a; won = won_a; over = over_a;
        end else begin
            seg = {15'd0, seg_b}; led = {29'd0, led_b}; s = s_b; b = b_b; won = won_b; over = over_b;
        end
        check({tag, ".seg"},    seg, e.seg);
        check({tag, ".led"},    {8'd0, led}, {8'd0, e.led});
        check({tag, ".strike"}, {36'd0, s}, {36'd0, e.s});
        check({tag, ".ball"},   {36'd0, b}, {36'd0, e.b});
        check({tag, ".won"},    {39'd0, won}, {39'd0, e.won});
        check({tag, ".over"},   {39'd0, over}, {39'd0, e.over});
    endtask

    task automatic check_zero(input int sel, input string tag);
        vec_t z;
        z.sel = sel; z.mask = '0; z.rep = 0; z.chk = 1'b1; z.seg = '0; z.led = '0;
        z.s = '0; z.b = '0; z.won = 1'b0; z.over = 1'b0;
        sb.push_back(z);
        compare(tag);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; act_a = 1'b1; act_b = 1'b1;
        btn_a = '0; btn_b = '0;

        // ---- instance a: 4 digits, 16 attempts ----
        add(0, U, 4, 1, s4(0,0,0,4), 0, 0, 0, 0, 0);
        st(0, L, 1); st(0, U, 3); st(0, L, 1); st(0, U, 2); st(0, L, 1);
        add(0, U, 1, 1, s4(1,2,3,4), 0, 0, 0, 0, 0);
        add(0, C, 1, 1, s4(9,17,9,17), 0, 0, 0, 0, 0);
        add(0, C, 1, 1, s4(0,0,0,0), 0, 0, 0, 0, 0);
        st(0, U, 1); st(0, L, 1); st(0, U, 3); st(0, L, 1); st(0, U, 2); st(0, L, 1);
        add(0, U, 4, 1, s4(4,2,3,1), 0, 0, 0, 0, 0);
        add(0, C, 1, 1, s4(2,5,2,18), 1, 2, 2, 0, 0);
        add(0, C, 1, 1, s4(4,2,3,1), 1, 2, 2, 0, 0);
        st(0, U, 3); st(0, L, 2); st(0, D, 1); st(0, L, 1);
        add(0, D, 3, 1, s4(1,1,3,4), 1, 2, 2, 0, 0);
        add(0, C|U, 1, 1, s4(10,11,12,12), 1, 2, 2, 0, 0);   // up dropped
        add(0, C, 1, 1, s4(1,1,3,4), 1, 2, 2, 0, 0);
        st(0, L|R, 1); st(0, L, 1);                           // left wins
        add(0, U|D, 1, 1, s4(1,2,3,4), 1, 2, 2, 0, 0);       // up wins
        add(0, C, 1, 1, s4(9,17,17,19), 3, 4, 0, 1, 1);
        add(0, C, 1, 1, s4(0,0,0,0), 0, 0, 0, 0, 0);
        add(0, D, 1, 1, s4(0,0,0,9), 0, 0, 0, 0, 0);         // 0 wraps to 9
        st(0, U, 1); st(0, R, 1);                             // 9 wraps to 0; cursor wraps to MSB
        add(0, U, 1, 1, s4(1,0,0,0), 0, 0, 0, 0, 0);
        st(0, R, 1); st(0, U, 1); st(0, R, 1); st(0, U, 2); st(0, R, 1);
        add(0, U, 3, 1, s4(1,1,2,3), 0, 0, 0, 0, 0);
        add(0, C, 1, 1, s4(10,11,12,12), 0, 0, 0, 0, 0);
        add(0, C, 1, 1, s4(1,1,2,3), 0, 0, 0, 0, 0);
        st(0, L, 2);
        add(0, D, 1, 1, s4(1,0,2,3), 0, 0, 0, 0, 0);
        add(0, C, 1, 1, s4(9,17,9,17), 0, 0, 0, 0, 0);
        add(0, C, 1, 1, s4(0,0,0,0), 0, 0, 0, 0, 0);
        add(0, U, 1, 1, s4(0,0,0,1), 0, 0, 0, 0, 0);

        // ---- instance b: 5 digits, 3 attempts, answer 01234, guess 43210 ----
        st(1, U, 4); st(1, L, 1); st(1, U, 3); st(1, L, 1); st(1, U, 2); st(1, L, 1);
        add(1, U, 1, 1, s5(0,1,2,3,4), 0, 0, 0, 0, 0);
        add(1, C, 1, 1, s5(9,17,9,17,31), 0, 0, 0, 0, 0);
        add(1, C, 1, 1, s5(0,0,0,0,0), 0, 0, 0, 0, 0);
        st(1, L, 1); st(1, U, 1); st(1, L, 1); st(1, U, 2); st(1, L, 1); st(1, U, 3); st(1, L, 1);
        add(1, U, 4, 1, s5(4,3,2,1,0), 0, 0, 0, 0, 0);
        add(1, C, 1, 1, s5(1,5,4,18,31), 1, 1, 4, 0, 0);
        st(1, C, 1);
        add(1, C, 1, 1, s5(1,5,4,18,31), 3, 1, 4, 0, 0);
        st(1, C, 1);
        add(1, C, 1, 1, s5(13,17,5,11,31), 7, 1, 4, 0, 1);

        // reset state
        repeat (3) @(negedge clk);
        check_zero(0, "reset_a");
        check_zero(1, "reset_b");
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            if (v.chk) sb.push_back(v);
            for (int r = 0; r < v.rep; r++) press(v.sel, v.mask);
            if (v.chk) compare($sformatf("vec%0d", i));
        end

        // active dropped for one cycle while b sits in GAME_LOSE
        @(negedge clk); act_b = 1'b0;
        @(negedge clk); act_b = 1'b1;
        check_zero(1, "inactive_b");
        add(1, U, 1, 1, s5(0,0,0,0,1), 0, 0, 0, 0, 0);
        sb.push_back(tbl[tbl.size()-1]);
        press(1, U);
        compare("after_inactive_b");

        // async reset while a is in INPUT_GUESS with a non-zero guess digit
        @(negedge clk); #2 rst_a = 1'b1;
        #1 check_zero(0, "async_reset_a");
        @(negedge clk); rst_a = 1'b0;
        @(negedge clk);
        add(0, U, 1, 1, s4(0,0,0,1), 0, 0, 0, 0, 0);
        sb.push_back(tbl[tbl.size()-1]);
        press(0, U);
        compare("after_reset_a");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
